// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// The optional round-robin tie-break is selected by defining DMEM_ARB_RR_EN.
package dmem_arbiter_pkg;

    // Arbiter FSM encodings
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_t;

    // Default number of cycles m1 may wait before it is given priority
    localparam int ARB_MAX_WAIT = 8;

    // Default address / data widths of the data memory
    localparam int ARB_ISIZE = 16;
    localparam int ARB_DSIZE = 16;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant selection for the two-master data-memory arbiter.
// In IDLE the tie goes to m0 unless prio1 is set; a lock state restricts
// the grant to its owner.
import dmem_arbiter_pkg::*;

module dmem_arb_pick (
    input  logic       req0,
    input  logic       req1,
    input  arb_state_t state,
    input  logic       prio1,
    output logic       gnt0,
    output logic       gnt1
);

    // Pick at most one master according to the current lock state
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            ARB_LOCK0: gnt0 = req0;
            ARB_LOCK1: gnt1 = req1;
            default: begin
                if (req0 && req1) begin
                    gnt0 = ~prio1;
                    gnt1 = prio1;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port data memory.
// Master 0 is the CPU load/store port, master 1 the DMA/debug port.
// Grants are combinational in the request cycle; read data comes back one
// cycle later, steered to the master that issued the read.
// Build option DMEM_ARB_RR_EN: round-robin tie-break instead of fixed
// priority with the m1 starvation counter.
import dmem_arbiter_pkg::*;

module dmem_arbiter #(
    parameter int AW       = ARB_ISIZE,
    parameter int DW       = ARB_DSIZE,
    parameter int MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_wen,
    output logic          mem_ren,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t state_reg;
    logic       rd_pend_reg;
    logic       rd_id_reg;
    logic       prio1;
    logic       pick_gnt0;
    logic       pick_gnt1;
    logic [1:0] gnt;
    logic [1:0] rvalid;

    dmem_arb_pick u_pick (
        .req0  (m0_req),
        .req1  (m1_req),
        .state (state_reg),
        .prio1 (prio1),
        .gnt0  (pick_gnt0),
        .gnt1  (pick_gnt1)
    );

    // No access may be issued while reset is held
    assign m0_gnt = pick_gnt0 & ~rst;
    assign m1_gnt = pick_gnt1 & ~rst;
    assign gnt    = {m1_gnt, m0_gnt};

    // Memory side: granted master drives the bus, m0 address when idle
    assign mem_addr  = m1_gnt ? m1_addr  : m0_addr;
    assign mem_wdata = m1_gnt ? m1_wdata : m0_wdata;
    assign mem_wen   = (m0_gnt & m0_we) | (m1_gnt & m1_we);
    assign mem_ren   = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);

    // Read data is broadcast; rvalid tells each master whether it is theirs
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;
    assign m0_rvalid = rvalid[0];
    assign m1_rvalid = rvalid[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
            assign rvalid[gi] = rd_pend_reg & (rd_id_reg == 1'(gi)) & ~rst;
        end
    endgenerate

    // Track the read issued this cycle so its data can be tagged next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_reg <= 1'b0;
            rd_id_reg   <= 1'b0;
        end else begin
            rd_pend_reg <= mem_ren;
            if (mem_ren) begin
                rd_id_reg <= gnt[1];
            end
        end
    end

    // Lock FSM: a locked grant keeps ownership until the owner's unlocked grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ARB_IDLE;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (m0_gnt && m0_lock) begin
                        state_reg <= ARB_LOCK0;
                    end else if (m1_gnt && m1_lock) begin
                        state_reg <= ARB_LOCK1;
                    end
                end
                ARB_LOCK0: begin
                    if (m0_gnt && !m0_lock) begin
                        state_reg <= ARB_IDLE;
                    end
                end
                ARB_LOCK1: begin
                    if (m1_gnt && !m1_lock) begin
                        state_reg <= ARB_IDLE;
                    end
                end
                default: state_reg <= ARB_IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Remembers which master was granted last; starts at m1 so m0 wins first
    logic last_gnt_reg;

    assign prio1 = ~last_gnt_reg;

    // Update the round-robin pointer on every issued access
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_reg <= 1'b1;
        end else if (m0_gnt || m1_gnt) begin
            last_gnt_reg <= m1_gnt;
        end
    end
`else
    // Cycles m1 has been kept waiting; saturates at MAX_WAIT
    logic [7:0] wait_cnt_reg;
    logic [7:0] wait_cnt_next;

    assign prio1 = (wait_cnt_reg == 8'(MAX_WAIT));

    // Next value of the starvation counter
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (!m1_req || m1_gnt) begin
            wait_cnt_next = 8'd0;
        end else if (wait_cnt_reg != 8'(MAX_WAIT)) begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
        end
    end

    // Starvation counter register; keeps counting while a lock is held
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg <= 8'd0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a scoreboard: stimulus pushes the
// expected grants and read returns, a monitor pops and compares them.
import dmem_arbiter_pkg::*;

module tb_dmem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m0_lock;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req, m1_we, m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          mem_wen, mem_ren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem_model [0:255];
    logic [7:0]    raddr_q;

    exp_t gnt_q[$];
    exp_t rd_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Single-port memory: synchronous write, registered read address
    always @(posedge clk) begin
        if (mem_wen) mem_model[mem_addr[7:0]] <= mem_wdata;
        if (mem_ren) raddr_q <= mem_addr[7:0];
    end
    assign mem_rdata = mem_model[raddr_q];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_gnt(input logic id, input logic [AW-1:0] a);
        gnt_q.push_back('{id: id, val: a});
    endtask

    task automatic push_rd(input logic id, input logic [DW-1:0] d);
        rd_q.push_back('{id: id, val: d});
    endtask

    // Monitor: every grant and every rvalid must match the next expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m0_gnt || m1_gnt) begin
                if (gnt_q.size() == 0) begin
                    check("unexpected_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
                end else begin
                    e = gnt_q.pop_front();
                    $display("t=%0t grant m%0d addr=%h", $time, m1_gnt, mem_addr);
                    check("gnt_id", {30'd0, m1_gnt, m0_gnt}, e.id ? 32'd2 : 32'd1);
                    check("gnt_addr", 32'(mem_addr), 32'(e.val));
                end
            end
            if (m0_rvalid || m1_rvalid) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
                end else begin
                    e = rd_q.pop_front();
                    $display("t=%0t rvalid m%0d data=%h", $time, m1_rvalid, mem_rdata);
                    check("rvalid_id", {30'd0, m1_rvalid, m0_rvalid}, e.id ? 32'd2 : 32'd1);
                    check("rdata", e.id ? 32'(m1_rdata) : 32'(m0_rdata), 32'(e.val));
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
        step();
        step();
        @(negedge clk);
        check("rst_outputs", {28'd0, m0_gnt, m1_gnt, m0_rvalid | m1_rvalid, mem_wen | mem_ren}, 32'd0);
        check("rst_state", 32'(dut.state_reg), 32'(ARB_IDLE));
`ifndef DMEM_ARB_RR_EN
        check("rst_wait_cnt", 32'(dut.wait_cnt_reg), 32'd0);
`endif
        step();
        rst = 1'b0;

        // Preload 0x0010 = 0xBEEF through m0
        step();
        m0_req = 1; m0_we = 1; m0_addr = 16'h0010; m0_wdata = 16'hBEEF;
        push_gnt(0, 16'h0010);
        @(negedge clk);

        // 1. read pipeline
        step();
        m0_we = 0;
        push_gnt(0, 16'h0010);
        push_rd(0, 16'hBEEF);
        @(negedge clk);
        check("t1_gnt", {31'd0, m0_gnt}, 32'd1);
        check("t1_ren", {31'd0, mem_ren}, 32'd1);
        step();
        m0_req = 0;
        @(negedge clk);
        check("t1_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd2);

        // Reset pulse returns the round-robin pointer to its start
        step(); rst = 1;
        step(); rst = 0;

        // 2. tie: m0 write then m1 read of the same address
        step();
        m0_req = 1; m0_we = 1; m0_addr = 16'h0004; m0_wdata = 16'h1234;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0004;
        push_gnt(0, 16'h0004);
        @(negedge clk);
        check("t2_tie", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        step();
        m0_req = 0;
        push_gnt(1, 16'h0004);
        push_rd(1, 16'h1234);
        @(negedge clk);
        check("t2_m1_next", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        step();
        m1_req = 0;
        @(negedge clk);
        check("t2_m1_rvalid", {31'd0, m1_rvalid}, 32'd1);

`ifndef DMEM_ARB_RR_EN
        // 3. starvation: m1 granted on its 9th waiting cycle
        step();
        m0_req = 1; m0_we = 1; m0_addr = 16'h0030; m0_wdata = 16'hAAAA;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0030;
        for (int k = 1; k <= 9; k++) begin
            if (k < 9) push_gnt(0, 16'h0030);
            else begin
                push_gnt(1, 16'h0030);
                push_rd(1, 16'hAAAA);
            end
            @(negedge clk);
            if (k == 8) check("t3_no_gnt_8", {31'd0, m1_gnt}, 32'd0);
            if (k == 9) begin
                check("t3_gnt_9", {30'd0, m1_gnt, m0_gnt}, 32'd2);
                check("t3_wait_sat", 32'(dut.wait_cnt_reg), 32'd8);
            end
            if (k < 9) step();
        end
        step();
        m1_req = 0;
        push_gnt(0, 16'h0030);
        @(negedge clk);
        check("t3_wait_clr", 32'(dut.wait_cnt_reg), 32'd0);
        step();
        m0_req = 0;
`endif

        // 4. lock held by m1 while m0 requests
        step();
        m1_req = 1; m1_we = 0; m1_lock = 1; m1_addr = 16'h0004;
        push_gnt(1, 16'h0004);
        push_rd(1, 16'h1234);
        @(negedge clk);
        check("t4_lock_gnt", {31'd0, m1_gnt}, 32'd1);
        step();
        m1_req = 0; m1_lock = 0;
        m0_req = 1; m0_we = 1; m0_addr = 16'h0040; m0_wdata = 16'h1111;
        @(negedge clk);
        check("t4_state", 32'(dut.state_reg), 32'(ARB_LOCK1));
        check("t4_stall0", {31'd0, m0_gnt}, 32'd0);
        for (int k = 1; k <= 2; k++) begin
            step();
            @(negedge clk);
            check("t4_stall", {31'd0, m0_gnt}, 32'd0);
        end
        step();
        m1_req = 1; m1_we = 1; m1_addr = 16'h0044; m1_wdata = 16'h2222;
        push_gnt(1, 16'h0044);
        @(negedge clk);
        check("t4_unlock", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        step();
        m1_req = 0;
        push_gnt(0, 16'h0040);
        @(negedge clk);
        check("t4_m0_after", {31'd0, m0_gnt}, 32'd1);
        check("t4_idle", 32'(dut.state_reg), 32'(ARB_IDLE));
        step();
        m0_req = 0;

        // 5. reset in the cycle after a locked read grant
        step();
        m0_req = 1; m0_we = 0; m0_lock = 1; m0_addr = 16'h0010;
        push_gnt(0, 16'h0010);
        @(negedge clk);
        step();
        rst = 1;
        m0_req = 0; m0_lock = 0;
        m1_req = 1; m1_we = 1; m1_addr = 16'h0050; m1_wdata = 16'h3333;
        @(negedge clk);
        check("t5_outputs", {28'd0, m0_gnt, m1_gnt, m0_rvalid | m1_rvalid, mem_wen | mem_ren}, 32'd0);
        step();
        @(negedge clk);
        check("t5_state", 32'(dut.state_reg), 32'(ARB_IDLE));
        step();
        rst = 0;
        push_gnt(1, 16'h0050);
        @(negedge clk);
        check("t5_lock_released", {31'd0, m1_gnt}, 32'd1);
        step();
        m1_req = 0;

`ifdef DMEM_ARB_RR_EN
        // 6. round-robin alternation from reset
        step(); rst = 1;
        step(); rst = 0;
        step();
        m0_req = 1; m0_we = 1; m0_addr = 16'h0060; m0_wdata = 16'h0606;
        m1_req = 1; m1_we = 1; m1_addr = 16'h0062; m1_wdata = 16'h0707;
        for (int k = 0; k < 4; k++) begin
            push_gnt(k[0], k[0] ? 16'h0062 : 16'h0060);
            @(negedge clk);
            check("t6_rr", {30'd0, m1_gnt, m0_gnt}, k[0] ? 32'd2 : 32'd1);
            step();
        end
        m0_req = 0; m1_req = 0;
`endif

        step();
        step();
        @(negedge clk);
        check("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
